// File: rtl/auto_nav_fsm_pkg.sv
// Shared constants for the little-car auto-navigation block: state codes,
// turn-direction encodings and the saturating counter helper.
package car_pkg;

  localparam int CNT_W   = 12;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [3:0] IDLE   = 4'b0000;
  localparam logic [3:0] FWD    = 4'b0110;
  localparam logic [3:0] TURN   = 4'b0111;
  localparam logic [3:0] SETTLE = 4'b1000;
  localparam logic [3:0] TURN2  = 4'b1001;
  localparam logic [3:0] GAP    = 4'b1010;
  localparam logic [3:0] FAULT  = 4'b1111;

  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/auto_nav_fsm_det_filter.sv
// Single-bit obstacle detector conditioner. AUTO_NAV_DEBOUNCE_EN selects a
// stable-count debouncer; otherwise a plain two-flop synchronizer.
module det_filter
  import car_pkg::*;
#(
  parameter int   DEBOUNCE_MS = 20,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_ms,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  if (DEBOUNCE_MS < 1 || DEBOUNCE_MS > CNT_MAX) begin : g_db_range
    $error("det_filter: DEBOUNCE_MS out of range");
  end

`ifdef AUTO_NAV_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Count consecutive samples that disagree with the filtered value; any
  // agreeing sample restarts the count.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (din != filt_q) begin
      if (cnt_q >= DB_LAST) filt_d = din;
      else                  cnt_d  = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk_ms or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= RST_VAL;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign dout = filt_q;
`else
  logic sync1_q, sync2_q;

  always_ff @(posedge clk_ms or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  assign dout = sync2_q;
`endif

endmodule

// File: rtl/auto_nav_fsm.sv
// Auto-drive navigation FSM: right-hand-rule maze policy with turn timeout.
// Detector filtering depends on AUTO_NAV_DEBOUNCE_EN (see det_filter).
module auto_nav_fsm
  import car_pkg::*;
#(
  parameter int DEBOUNCE_MS     = 20,
  parameter int SETTLE_MS       = 600,
  parameter int TURN_TIMEOUT_MS = 2000
) (
  input  logic       clk_ms,
  input  logic       rst_n,
  input  logic       mode_auto,
  input  logic       front_det,
  input  logic       left_det,
  input  logic       right_det,
  input  logic       back_det,
  input  logic       finish_turning,
  output logic [3:0] state,
  output logic       left_right,
  output logic       move_forward,
  output logic       nav_fault
);

  if (SETTLE_MS < 1 || SETTLE_MS > CNT_MAX) begin : g_settle_range
    $error("auto_nav_fsm: SETTLE_MS out of range");
  end
  if (TURN_TIMEOUT_MS < 1 || TURN_TIMEOUT_MS > CNT_MAX) begin : g_timeout_range
    $error("auto_nav_fsm: TURN_TIMEOUT_MS out of range");
  end

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_MS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TURN_TIMEOUT_MS - 1);

  logic front_f, left_f, right_f, back_f;
  logic unused_back;

  det_filter #(.DEBOUNCE_MS(DEBOUNCE_MS), .RST_VAL(1'b0)) u_front (
    .clk_ms(clk_ms), .rst_n(rst_n), .din(front_det), .dout(front_f));
  det_filter #(.DEBOUNCE_MS(DEBOUNCE_MS), .RST_VAL(1'b1)) u_left (
    .clk_ms(clk_ms), .rst_n(rst_n), .din(left_det), .dout(left_f));
  det_filter #(.DEBOUNCE_MS(DEBOUNCE_MS), .RST_VAL(1'b1)) u_right (
    .clk_ms(clk_ms), .rst_n(rst_n), .din(right_det), .dout(right_f));
  det_filter #(.DEBOUNCE_MS(DEBOUNCE_MS), .RST_VAL(1'b1)) u_back (
    .clk_ms(clk_ms), .rst_n(rst_n), .din(back_det), .dout(back_f));

  // Filtered rear detector is kept for the future reverse policy.
  assign unused_back = back_f;

  logic [3:0]       state_q, state_d;
  logic             lr_q, lr_d, dir_d;
  logic             mv_q, mv_d;
  logic             fault_q, fault_d;
  logic             uturn_q, uturn_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;

  always_ff @(posedge clk_ms or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lr_q     <= LR_LEFT;
      mv_q     <= 1'b0;
      fault_q  <= 1'b0;
      uturn_q  <= 1'b0;
      settle_q <= '0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      lr_q     <= lr_d;
      mv_q     <= mv_d;
      fault_q  <= fault_d;
      uturn_q  <= uturn_d;
      settle_q <= settle_d;
      dwell_q  <= dwell_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    uturn_d  = uturn_q;
    dir_d    = lr_q;
    settle_d = settle_q;
    dwell_d  = dwell_q;
    if (!mode_auto) begin
      state_d = IDLE;
      uturn_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FWD;
          uturn_d = 1'b0;
        end
        FWD: begin
          if (!right_f) begin
            state_d = TURN;
            dir_d   = LR_RIGHT;
            uturn_d = 1'b0;
          end else if (!front_f) begin
            state_d = FWD;
          end else if (!left_f) begin
            state_d = TURN;
            dir_d   = LR_LEFT;
            uturn_d = 1'b0;
          end else begin
            state_d = TURN;
            dir_d   = LR_RIGHT;
            uturn_d = 1'b1;
          end
        end
        TURN: begin
          // Completion is checked before the timeout so a simultaneous finish wins.
          if (finish_turning)             state_d = uturn_q ? GAP : SETTLE;
          else if (dwell_q >= TIMEOUT_LAST) state_d = FAULT;
          else                            dwell_d = sat_inc(dwell_q);
        end
        GAP: begin
          state_d = TURN2;
          dir_d   = LR_RIGHT;
        end
        TURN2: begin
          if (finish_turning) begin
            state_d = SETTLE;
            uturn_d = 1'b0;
          end else if (dwell_q >= TIMEOUT_LAST) begin
            state_d = FAULT;
          end else begin
            dwell_d = sat_inc(dwell_q);
          end
        end
        SETTLE: begin
          if (settle_q >= SETTLE_LAST) state_d = FWD;
          else                         settle_d = sat_inc(settle_q);
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
    // Every state entry starts both dwell and settle timing from zero.
    if (state_d != state_q) begin
      settle_d = '0;
      dwell_d  = '0;
    end
  end

  always_comb begin
    lr_d = lr_q;
    if ((state_d == TURN || state_d == TURN2) && state_d != state_q) lr_d = dir_d;
    mv_d    = (state_d == FWD) || (state_d == SETTLE);
    fault_d = fault_q;
    if (state_d == FAULT)     fault_d = 1'b1;
    else if (state_d == IDLE) fault_d = 1'b0;
  end

  assign state        = state_q;
  assign left_right   = lr_q;
  assign move_forward = mv_q;
  assign nav_fault    = fault_q;

endmodule

// File: tb/tb_auto_nav_fsm.sv
// Directed bench for auto_nav_fsm: expected output tuples are queued as each
// stimulus is applied and checked when the DUT's state next changes.
module tb_auto_nav_fsm;

  localparam int DB    = 20;
  localparam int SET_T = 600;
  localparam int TO_T  = 2000;
`ifdef AUTO_NAV_DEBOUNCE_EN
  localparam int LAT = DB + 1;
`else
  localparam int LAT = 3;
`endif

  localparam logic [3:0] S_IDLE   = 4'h0;
  localparam logic [3:0] S_FWD    = 4'h6;
  localparam logic [3:0] S_TURN   = 4'h7;
  localparam logic [3:0] S_SETTLE = 4'h8;
  localparam logic [3:0] S_TURN2  = 4'h9;
  localparam logic [3:0] S_GAP    = 4'hA;
  localparam logic [3:0] S_FAULT  = 4'hF;

  typedef struct packed {
    logic [3:0] st;
    logic       lr;
    logic       mv;
    logic       flt;
  } obs_t;

  logic       clk_ms = 1'b0;
  logic       rst_n = 1'b1;
  logic       mode_auto = 1'b0;
  logic       front_det = 1'b0;
  logic       left_det = 1'b1;
  logic       right_det = 1'b1;
  logic       back_det = 1'b1;
  logic       finish_turning = 1'b0;
  logic [3:0] state;
  logic       left_right;
  logic       move_forward;
  logic       nav_fault;

  int   tests = 0;
  int   fails = 0;
  obs_t sb[$];

  always #5 clk_ms = ~clk_ms;

  auto_nav_fsm #(
    .DEBOUNCE_MS(DB),
    .SETTLE_MS(SET_T),
    .TURN_TIMEOUT_MS(TO_T)
  ) dut (
    .clk_ms(clk_ms),
    .rst_n(rst_n),
    .mode_auto(mode_auto),
    .front_det(front_det),
    .left_det(left_det),
    .right_det(right_det),
    .back_det(back_det),
    .finish_turning(finish_turning),
    .state(state),
    .left_right(left_right),
    .move_forward(move_forward),
    .nav_fault(nav_fault)
  );

  task automatic tick();
    @(posedge clk_ms);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic lr, input logic mv, input logic flt);
    sb.push_back(obs_t'({st, lr, mv, flt}));
  endtask

  // Wait (bounded) for the next state change, then compare it with the queue head.
  task automatic next_change(input string tag, input int budget, input int exp_cycles);
    logic [3:0] prev;
    obs_t       e;
    obs_t       o;
    int         n;
    prev = state;
    n    = 0;
    while (state === prev && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      o = obs_t'({state, left_right, move_forward, nav_fault});
      chk({tag, "_out"}, 32'(o), 32'(e));
      if (exp_cycles >= 0) chk({tag, "_cyc"}, 32'(n), 32'(exp_cycles));
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_lr", 32'(left_right), 32'd0);
    chk("rst_mv", 32'(move_forward), 32'd0);
    chk("rst_fault", 32'(nav_fault), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_hold", 32'(state), 32'(S_IDLE));

    mode_auto = 1'b1;
    push(S_FWD, 1'b0, 1'b1, 1'b0);
    next_change("enter_fwd", 5, 1);
    repeat (LAT + 20) tick();
    chk("fwd_no_turn", 32'(state), 32'(S_FWD));

    back_det = 1'b0;
    repeat (LAT + 10) tick();
    chk("back_ignored", 32'(state), 32'(S_FWD));
    back_det = 1'b1;

    // Right turn, then settle.
    right_det = 1'b0;
    push(S_TURN, 1'b1, 1'b0, 1'b0);
    next_change("right_turn", LAT + 10, LAT);
    right_det = 1'b1;
    repeat (5) tick();
    finish_turning = 1'b1;
    push(S_SETTLE, 1'b1, 1'b1, 1'b0);
    next_change("turn_done", 3, 1);
    finish_turning = 1'b0;
    push(S_FWD, 1'b1, 1'b1, 1'b0);
    next_change("settle_end", SET_T + 20, SET_T);

    // Dead end: U-turn through GAP.
    front_det = 1'b1;
    push(S_TURN, 1'b1, 1'b0, 1'b0);
    next_change("uturn_start", LAT + 10, LAT);
    finish_turning = 1'b1;
    push(S_GAP, 1'b1, 1'b0, 1'b0);
    next_change("uturn_gap", 3, 1);
    finish_turning = 1'b0;
    push(S_TURN2, 1'b1, 1'b0, 1'b0);
    next_change("gap_len", 3, 1);
    front_det = 1'b0;
    repeat (4) tick();
    finish_turning = 1'b1;
    push(S_SETTLE, 1'b1, 1'b1, 1'b0);
    next_change("turn2_done", 3, 1);
    finish_turning = 1'b0;
    push(S_FWD, 1'b1, 1'b1, 1'b0);
    next_change("uturn_settle", SET_T + 20, SET_T);

    // Left turn that never completes.
    front_det = 1'b1;
    left_det  = 1'b0;
    push(S_TURN, 1'b0, 1'b0, 1'b0);
    next_change("left_turn", LAT + 10, LAT);
    push(S_FAULT, 1'b0, 1'b0, 1'b1);
    next_change("timeout", TO_T + 20, TO_T);
    front_det = 1'b0;
    left_det  = 1'b1;
    repeat (10) tick();
    chk("fault_stays", 32'(state), 32'(S_FAULT));
    chk("fault_sticky", 32'(nav_fault), 32'd1);
    mode_auto = 1'b0;
    push(S_IDLE, 1'b0, 1'b0, 1'b0);
    next_change("fault_clear", 3, 1);
    repeat (LAT + 5) tick();

    // finish_turning on the same edge as the timeout.
    mode_auto = 1'b1;
    push(S_FWD, 1'b0, 1'b1, 1'b0);
    next_change("reenter_fwd", 3, 1);
    right_det = 1'b0;
    push(S_TURN, 1'b1, 1'b0, 1'b0);
    next_change("race_turn", LAT + 10, LAT);
    right_det = 1'b1;
    repeat (TO_T - 1) tick();
    chk("race_pre", 32'(state), 32'(S_TURN));
    finish_turning = 1'b1;
    push(S_SETTLE, 1'b1, 1'b1, 1'b0);
    next_change("race_finish", 3, 1);
    finish_turning = 1'b0;
    push(S_FWD, 1'b1, 1'b1, 1'b0);
    next_change("race_settle", SET_T + 20, SET_T);

    // Reset in the middle of TURN2.
    front_det = 1'b1;
    push(S_TURN, 1'b1, 1'b0, 1'b0);
    next_change("u2_start", LAT + 10, LAT);
    finish_turning = 1'b1;
    push(S_GAP, 1'b1, 1'b0, 1'b0);
    next_change("u2_gap", 3, 1);
    finish_turning = 1'b0;
    push(S_TURN2, 1'b1, 1'b0, 1'b0);
    next_change("u2_turn2", 3, 1);
    front_det = 1'b0;
    repeat (5) tick();
    #2;
    rst_n     = 1'b0;
    mode_auto = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'(S_IDLE));
    chk("async_rst_lr", 32'(left_right), 32'd0);
    chk("async_rst_mv", 32'(move_forward), 32'd0);
    chk("async_rst_fault", 32'(nav_fault), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_idle", 32'(state), 32'(S_IDLE));
    mode_auto = 1'b1;
    push(S_FWD, 1'b0, 1'b1, 1'b0);
    next_change("post_rst_fwd", 3, 1);
    repeat (LAT + 5) tick();
    chk("post_rst_hold", 32'(state), 32'(S_FWD));
    right_det = 1'b0;
    push(S_TURN, 1'b1, 1'b0, 1'b0);
    next_change("post_rst_turn", LAT + 10, LAT);
    right_det = 1'b1;
    finish_turning = 1'b1;
    push(S_SETTLE, 1'b1, 1'b1, 1'b0);
    next_change("uturn_flag_lost", 3, 1);
    finish_turning = 1'b0;
    push(S_FWD, 1'b1, 1'b1, 1'b0);
    next_change("post_rst_settle", SET_T + 20, SET_T);

`ifdef AUTO_NAV_DEBOUNCE_EN
    right_det = 1'b0;
    repeat (10) tick();
    right_det = 1'b1;
    repeat (DB + 20) tick();
    chk("glitch_ignored", 32'(state), 32'(S_FWD));
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
